bias_bank_streamer: RTL
=======================

Name: bias_bank_streamer

Overview:
- Programmable successor to the per-layer hardwired bias tables.
- Holds signed biases for all CNN layers in one on-chip bank, with a per-layer descriptor table (base, count).
- On a start request for a layer, streams that layer's biases one channel per beat over a valid/ready interface to the conv/FC accumulator stage.
- Depth, width, layer count and max channels are parameters.

Parameters:
- BIAS_W, 16, bias width in bits (two's complement).
- DEPTH, 256, bias bank entries.
- NUM_LAYERS, 16, descriptor table entries.
- MAX_CH, 48, max channels per layer; descriptor count range is 0..MAX_CH.
- AW, $clog2(DEPTH), bank address width.
- LW, $clog2(NUM_LAYERS), layer index width.
- CW, $clog2(MAX_CH+1), count and channel width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  bank write strobe.
- cfg_addr  in  AW  bank write address.
- cfg_data  in  BIAS_W  bank write data.
- desc_we  in  1  descriptor write strobe.
- desc_layer  in  LW  descriptor index.
- desc_base  in  AW  first bank address of the layer.
- desc_count  in  CW  channel count of the layer.
- start  in  1  start-stream request.
- start_layer  in  LW  layer to stream.
- busy  out  1  stream in progress.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer ready.
- out_data  out  BIAS_W  bias value.
- out_ch  out  CW  channel index of the beat.
- out_last  out  1  final beat of the layer.
- err  out  1  one-cycle error pulse.

Behaviour:
- Reset: busy, out_valid, out_last, err = 0; out_data, out_ch = 0; FSM returns to IDLE; all descriptor counts = 0. Bank contents are not reset.
- FSM states:
  - IDLE: start accepted only here.
  - PRIME: first bank read in flight.
  - STREAM: beats issuing.
- IDLE, start high:
  - If desc_count[start_layer]==0 or desc_count>MAX_CH: pulse err for 1 cycle, stay in IDLE.
  - Otherwise latch base and count, set busy, go to PRIME.
- Bank is a synchronous read with 1-cycle latency. With start accepted in cycle T, the first out_valid is in cycle T+2.
- Throughput: with out_ready held high, one beat per cycle. The last beat is in cycle T+1+count, and busy drops the cycle after the last handshake.
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_ch and out_last hold stable.
  - out_valid never drops without a transfer.
- The output stage has a 1-entry prefetch (skid) register, so full throughput holds across ready toggling with no lost or duplicated beats.
- Beat k carries bank[(base+k) mod DEPTH]. Addresses wrap silently at DEPTH.
- out_ch = k. out_last = 1 only on beat count-1.
- start while busy: ignored, no err.
- cfg_we or desc_we while busy: write dropped, err pulsed. In IDLE, writes take effect next cycle.
- Simultaneous desc_we and start in IDLE: start uses the old descriptor.
- rst mid-stream: next cycle out_valid=0, busy=0, state IDLE. The partial stream is abandoned.

Optional Feature:
- Macro: BIAS_PACKED_OUT_EN.
- When defined, adds two outputs:
  - packed_vec, out, MAX_CH*BIAS_W: channel k at bits [k*BIAS_W +: BIAS_W], unused slots 0. Cleared at start acceptance and filled on each handshake.
  - packed_valid, out, 1: one-cycle pulse the cycle after the last handshake.
- The packed output preserves the legacy wide-vector interface for consumers not yet converted to streaming.
- When not defined, neither port exists and no packing registers are built.

Decomposition:
- Package bias_stream_pkg holds:
  - default BIAS_W, DEPTH, NUM_LAYERS, MAX_CH;
  - FSM state encoding (IDLE=0, PRIME=1, STREAM=2);
  - descriptor struct/typedef {base, count}.
- One sub-module: bias_mem, a 1R1W synchronous-read RAM of DEPTH x BIAS_W. Read and write never collide because writes are blocked while busy.

Test Plan:
- Load 12 biases 0x0001..0x000C at addr 0, desc layer1 = {0, 12}, start layer1 with out_ready=1:
  - first valid at T+2;
  - 12 consecutive beats of data 1..12, out_ch 0..11;
  - out_last only on ch 11;
  - busy low at T+14.
- Same load, out_ready toggling 1,0,0,1,... → all 12 values delivered in order, data held stable while stalled, no duplicates.
- start on a layer with count 0, and separately cfg_we during a stream → err pulses for 1 cycle; no out_valid for the first case; the bank word is unchanged for the second.
- desc {base=DEPTH-2, count=4} with bank[254]=0xFFF0, bank[255]=0x0005, bank[0]=0x7FFF, bank[1]=0x8000 → beats 0xFFF0, 0x0005, 0x7FFF, 0x8000.
- rst asserted on beat 5 of a 24-channel stream → out_valid=0 next cycle; a new start then streams from ch 0 correctly.
- BIAS_PACKED_OUT_EN defined, 10-channel layer → packed_valid pulse with packed_vec[159:0] equal to the concatenated biases and upper bits 0.

Source files
------------

// File: rtl/bias_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : bias_stream_pkg
//  Description : Shared definitions for the bias bank streamer: default
//                geometry, FSM state encoding and the layer descriptor type.
//  Revision    : 1.0  initial release
// ============================================================================
package bias_stream_pkg;

    // Default geometry of the bias bank.
    localparam int c_DEF_BIAS_W     = 16;
    localparam int c_DEF_DEPTH      = 256;
    localparam int c_DEF_NUM_LAYERS = 16;
    localparam int c_DEF_MAX_CH     = 48;
    localparam int c_DEF_AW         = $clog2(c_DEF_DEPTH);
    localparam int c_DEF_CW         = $clog2(c_DEF_MAX_CH + 1);

    // Streamer FSM encoding.
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE   = 2'd0;
    localparam state_t c_ST_PRIME  = 2'd1;
    localparam state_t c_ST_STREAM = 2'd2;

    // Per-layer descriptor at the default geometry.
    typedef struct packed {
        logic [c_DEF_AW-1:0] base;
        logic [c_DEF_CW-1:0] count;
    } desc_t;

endpackage
`default_nettype wire

// File: rtl/bias_mem.sv
`default_nettype none
// ============================================================================
//  Module      : bias_mem
//  Description : 1R1W bias bank, DEPTH x BIAS_W, synchronous read with one
//                cycle of latency. Read data holds while re is low, so the
//                streamer can use the read register as a pipeline stage.
//                Contents are not reset.
//  Ports       : clk           clock
//                we/waddr/wdata write port
//                re/raddr      read enable / address
//                rdata         registered read data
//  Revision    : 1.0  initial release
// ============================================================================
module bias_mem #(
    parameter int DEPTH  = 256,
    parameter int BIAS_W = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [BIAS_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [BIAS_W-1:0] rdata
);

    logic [BIAS_W-1:0] r_mem [DEPTH];
    logic [BIAS_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/bias_bank_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : bias_bank_streamer
//  Description : Programmable bias bank with a per-layer descriptor table.
//                A start request streams the selected layer's biases one
//                channel per beat over valid/ready.
//  Ports       : clk, rst                    clock, sync active-high reset
//                cfg_we/cfg_addr/cfg_data    bias bank write
//                desc_we/desc_layer/
//                desc_base/desc_count        descriptor write
//                start/start_layer           stream request
//                busy                        stream in progress
//                out_valid/out_ready/
//                out_data/out_ch/out_last    beat stream
//                err                         one-cycle error pulse
//  Option      : BIAS_PACKED_OUT_EN adds packed_vec / packed_valid, a wide
//                vector of the whole layer for unconverted consumers.
//  Revision    : 1.0  initial release
// ============================================================================
module bias_bank_streamer
    import bias_stream_pkg::*;
#(
    parameter int BIAS_W     = c_DEF_BIAS_W,
    parameter int DEPTH      = c_DEF_DEPTH,
    parameter int NUM_LAYERS = c_DEF_NUM_LAYERS,
    parameter int MAX_CH     = c_DEF_MAX_CH,
    parameter int AW         = $clog2(DEPTH),
    parameter int LW         = $clog2(NUM_LAYERS),
    parameter int CW         = $clog2(MAX_CH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [BIAS_W-1:0] cfg_data,
    input  logic              desc_we,
    input  logic [LW-1:0]     desc_layer,
    input  logic [AW-1:0]     desc_base,
    input  logic [CW-1:0]     desc_count,
    input  logic              start,
    input  logic [LW-1:0]     start_layer,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BIAS_W-1:0] out_data,
    output logic [CW-1:0]     out_ch,
    output logic              out_last,
    output logic              err
`ifdef BIAS_PACKED_OUT_EN
    ,
    output logic [MAX_CH*BIAS_W-1:0] packed_vec,
    output logic                     packed_valid
`endif
);

    localparam logic [CW-1:0] c_MAX_CH    = CW'(MAX_CH);
    localparam logic [AW-1:0] c_LAST_ADDR = AW'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [AW-1:0]     r_desc_base [NUM_LAYERS];
    logic [CW-1:0]     r_desc_cnt  [NUM_LAYERS];

    // Read issue side.
    logic [AW-1:0]     r_addr;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_issued;

    // Stage A: the bank read register plus its channel tag.
    logic              r_a_vld;
    logic [CW-1:0]     r_a_ch;
    logic              r_a_last;

    // Skid register: catches stage A when the consumer stalls.
    logic              r_s_vld;
    logic [BIAS_W-1:0] r_s_data;
    logic [CW-1:0]     r_s_ch;
    logic              r_s_last;

    logic              r_err;

    logic              w_idle;
    logic [CW-1:0]     w_start_cnt;
    logic              w_start_bad;
    logic              w_start_ok;
    logic              w_wr_blocked;
    logic              w_issue;
    logic              w_hs;
    logic              w_a_free;
    logic [BIAS_W-1:0] w_rdata;

    assign w_idle       = (r_state == c_ST_IDLE);
    assign w_start_cnt  = r_desc_cnt[start_layer];
    assign w_start_bad  = w_idle && start &&
                          ((w_start_cnt == '0) || (w_start_cnt > c_MAX_CH));
    assign w_start_ok   = w_idle && start && !w_start_bad;
    assign w_wr_blocked = !w_idle && (cfg_we || desc_we);

    // A new read may land in stage A only if A is empty or is leaving this
    // cycle (either to the consumer or into an empty skid register).
    assign w_issue = ((r_state == c_ST_PRIME) || (r_state == c_ST_STREAM)) &&
                     (r_issued != r_cnt) &&
                     (!r_a_vld || !r_s_vld || out_ready);

    // The skid register, when full, always holds the older beat.
    assign out_valid = r_s_vld || r_a_vld;
    assign out_data  = r_s_vld ? r_s_data : (r_a_vld ? w_rdata  : '0);
    assign out_ch    = r_s_vld ? r_s_ch   : (r_a_vld ? r_a_ch   : '0);
    assign out_last  = r_s_vld ? r_s_last : (r_a_vld && r_a_last);
    assign busy      = !w_idle;
    assign err       = r_err;

    assign w_hs     = out_valid && out_ready;
    assign w_a_free = r_a_vld && (!r_s_vld || w_hs);

    bias_mem #(
        .DEPTH  (DEPTH),
        .BIAS_W (BIAS_W),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (cfg_we && w_idle),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .re    (w_issue),
        .raddr (r_addr),
        .rdata (w_rdata)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_start_ok) w_state_nxt = c_ST_PRIME;
            c_ST_PRIME:  w_state_nxt = c_ST_STREAM;
            c_ST_STREAM: if (w_hs && out_last) w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ---------------------------------------------------- descriptor table
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                r_desc_base[i] <= '0;
                r_desc_cnt[i]  <= '0;
            end
        end else if (desc_we && w_idle) begin
            r_desc_base[desc_layer] <= desc_base;
            r_desc_cnt[desc_layer]  <= desc_count;
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_cnt    <= '0;
            r_issued <= '0;
            r_a_vld  <= 1'b0;
            r_a_ch   <= '0;
            r_a_last <= 1'b0;
            r_s_vld  <= 1'b0;
            r_s_data <= '0;
            r_s_ch   <= '0;
            r_s_last <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_start_bad || w_wr_blocked;

            if (w_start_ok) begin
                r_addr   <= r_desc_base[start_layer];
                r_cnt    <= w_start_cnt;
                r_issued <= '0;
            end else if (w_issue) begin
                r_addr   <= (r_addr == c_LAST_ADDR) ? '0 : r_addr + 1'b1;
                r_issued <= r_issued + 1'b1;
            end

            if (w_issue) begin
                r_a_vld  <= 1'b1;
                r_a_ch   <= r_issued;
                r_a_last <= (r_issued == r_cnt - 1'b1);
            end else if (w_a_free) begin
                r_a_vld  <= 1'b0;
            end

            if (r_s_vld) begin
                if (w_hs) begin
                    if (r_a_vld) begin
                        r_s_data <= w_rdata;
                        r_s_ch   <= r_a_ch;
                        r_s_last <= r_a_last;
                    end else begin
                        r_s_vld  <= 1'b0;
                    end
                end
            end else if (r_a_vld && !w_hs) begin
                r_s_vld  <= 1'b1;
                r_s_data <= w_rdata;
                r_s_ch   <= r_a_ch;
                r_s_last <= r_a_last;
            end
        end
    end

`ifdef BIAS_PACKED_OUT_EN
    // ------------------------------------------------------- packed output
    logic [MAX_CH*BIAS_W-1:0] r_packed_vec;
    logic                     r_packed_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_packed_vec   <= '0;
            r_packed_valid <= 1'b0;
        end else begin
            r_packed_valid <= w_hs && out_last;
            if (w_start_ok) begin
                r_packed_vec <= '0;
            end else if (w_hs) begin
                for (int k = 0; k < MAX_CH; k++) begin
                    if (out_ch == CW'(k)) begin
                        r_packed_vec[k*BIAS_W +: BIAS_W] <= out_data;
                    end
                end
            end
        end
    end

    assign packed_vec   = r_packed_vec;
    assign packed_valid = r_packed_valid;
`endif

endmodule
`default_nettype wire
